// File: rtl/distortion_mc.sv
// Time-multiplexed multi-channel distortion stage: one frame per handshake,
// channels processed serially through a registered abs/drive stage and a clip/mix stage.
//
// state | meaning
// IDLE  | waiting for a frame, in_ready high
// RUN   | feeding channel r_k into stage 1, one per cycle
// DRAIN | last channel leaves stage 2
// DONE  | out_valid pulse, out_data complete
module distortion_mc #(
    parameter int W          = 32,
    parameter int CH         = 2,
    parameter int RAMP_SHIFT = 4
) (
    input  logic            CLOCK_50,
    input  logic            resetn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [CH*W-1:0] in_data,
    input  logic            enable,
    input  logic [1:0]      mode,
    input  logic [1:0]      drive,
    input  logic [1:0]      makeup,
    input  logic [W-1:0]    soft_thresh,
    input  logic [W-1:0]    hard_thresh,
    output logic            out_valid,
    output logic [CH*W-1:0] out_data,
    output logic            active
);
    localparam int KW = (CH > 1) ? $clog2(CH) : 1;
    localparam int GW = RAMP_SHIFT + 1;
    localparam int CW = W + 2;
    localparam int MW = W + RAMP_SHIFT + 2;
    localparam logic [GW-1:0] G_MAX = GW'(2 ** RAMP_SHIFT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [W-1:0]         W_MAX   = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]         W_MIN   = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W+3:0]  X_MAX   = {5'b00000, {(W-1){1'b1}}};
    localparam logic signed [W+3:0]  X_MIN   = {5'b11111, {(W-1){1'b0}}};
    localparam logic signed [W+5:0]  WET_MAX = {7'b0000000, {(W-1){1'b1}}};
    localparam logic signed [W+5:0]  WET_MIN = {7'b1111111, {(W-1){1'b0}}};
    localparam logic signed [MW-1:0] Y_MAX   = {{(RAMP_SHIFT+3){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [MW-1:0] Y_MIN   = {{(RAMP_SHIFT+3){1'b1}}, {(W-1){1'b0}}};

    logic [1:0]      r_state;
    logic [KW-1:0]   r_k;
    logic [CH*W-1:0] r_frame;
    logic [1:0]      r_mode;
    logic [1:0]      r_drive;
    logic [1:0]      r_makeup;
    logic [W-1:0]    r_soft;
    logic [W-1:0]    r_hard;
    logic [GW-1:0]   r_g;
    logic            r_s1_valid;
    logic [KW-1:0]   r_s1_k;
    logic            r_s1_sign;
    logic [W-1:0]    r_s1_abs;
    logic [W-1:0]    r_s1_dry;
    logic [CH*W-1:0] r_out_data;

    logic                 w_accept;
    logic [W-1:0]         w_dry;
    logic signed [W+3:0]  w_x_wide;
    logic [W-1:0]         w_x;
    logic [W-1:0]         w_abs;
    logic [CW-1:0]        w_a;
    logic [CW-1:0]        w_s;
    logic [CW-1:0]        w_h;
    logic [CW-1:0]        w_c;
    logic signed [W+5:0]  w_c_signed;
    logic signed [W+5:0]  w_wet_wide;
    logic [W-1:0]         w_wet;
    logic signed [MW-1:0] w_dry_m;
    logic signed [MW-1:0] w_wet_m;
    logic signed [MW-1:0] w_g_m;
    logic signed [MW-1:0] w_prod;
    logic signed [MW-1:0] w_y_wide;
    logic [W-1:0]         w_y;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign active    = (r_g != '0);
    assign out_data  = r_out_data;
    assign w_accept  = in_valid & in_ready;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_k      <= '0;
            r_frame  <= '0;
            r_mode   <= '0;
            r_drive  <= '0;
            r_makeup <= '0;
            r_soft   <= '0;
            r_hard   <= '0;
            r_g      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_frame  <= in_data;
                        r_mode   <= mode;
                        r_drive  <= drive;
                        r_makeup <= makeup;
                        r_soft   <= soft_thresh;
                        r_hard   <= (hard_thresh < soft_thresh) ? soft_thresh : hard_thresh;
                        if (enable && r_g != G_MAX)
                            r_g <= r_g + 1'b1;
                        else if (!enable && r_g != '0)
                            r_g <= r_g - 1'b1;
                        r_k      <= '0;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_k == KW'(CH-1))
                        r_state <= S_DRAIN;
                    else
                        r_k <= r_k + 1'b1;
                end
                S_DRAIN: r_state <= S_DONE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Stage 1: pre-gain with saturation, then sign/magnitude split.
    always_comb begin
        w_dry    = r_frame[r_k*W +: W];
        w_x_wide = {{4{w_dry[W-1]}}, w_dry} <<< r_drive;
        if (w_x_wide > X_MAX)
            w_x = W_MAX;
        else if (w_x_wide < X_MIN)
            w_x = W_MIN;
        else
            w_x = w_x_wide[W-1:0];
        if (w_x == W_MIN)
            w_abs = W_MAX;
        else if (w_x[W-1])
            w_abs = -w_x;
        else
            w_abs = w_x;
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_s1_valid <= 1'b0;
            r_s1_k     <= '0;
            r_s1_sign  <= 1'b0;
            r_s1_abs   <= '0;
            r_s1_dry   <= '0;
        end else begin
            r_s1_valid <= (r_state == S_RUN);
            r_s1_k     <= r_k;
            r_s1_sign  <= w_x[W-1];
            r_s1_abs   <= w_abs;
            r_s1_dry   <= w_dry;
        end
    end

    // Stage 2: clip on magnitude (two guard bits hold S + (H-S)/2 and 2S), makeup, wet/dry mix.
    always_comb begin
        w_a = {2'b00, r_s1_abs};
        w_s = {2'b00, r_soft};
        w_h = {2'b00, r_hard};
        case (r_mode)
            2'b01: begin
                if (w_a < w_s)
                    w_c = w_a;
                else if (w_a < w_h)
                    w_c = w_s + ((w_a - w_s) >> 1);
                else
                    w_c = w_s + ((w_h - w_s) >> 1);
            end
            2'b10:   w_c = (w_a < w_s) ? w_a : w_s;
            2'b11: begin
                if (w_a <= w_s)
                    w_c = w_a;
                else if ({1'b0, r_soft, 1'b0} > w_a)
                    w_c = {1'b0, r_soft, 1'b0} - w_a;
                else
                    w_c = '0;
            end
            default: w_c = w_a;
        endcase

        w_c_signed = $signed({4'b0000, w_c});
        w_wet_wide = (r_s1_sign ? -w_c_signed : w_c_signed) <<< r_makeup;
        if (w_wet_wide > WET_MAX)
            w_wet = W_MAX;
        else if (w_wet_wide < WET_MIN)
            w_wet = W_MIN;
        else
            w_wet = w_wet_wide[W-1:0];

        w_dry_m  = $signed({{(RAMP_SHIFT+2){r_s1_dry[W-1]}}, r_s1_dry});
        w_wet_m  = $signed({{(RAMP_SHIFT+2){w_wet[W-1]}}, w_wet});
        w_g_m    = $signed({{(MW-GW){1'b0}}, r_g});
        w_prod   = (w_wet_m - w_dry_m) * w_g_m;
        w_y_wide = (w_prod >>> RAMP_SHIFT) + w_dry_m;
        if (w_y_wide > Y_MAX)
            w_y = W_MAX;
        else if (w_y_wide < Y_MIN)
            w_y = W_MIN;
        else
            w_y = w_y_wide[W-1:0];
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn)
            r_out_data <= '0;
        else if (r_s1_valid)
            r_out_data[r_s1_k*W +: W] <= w_y;
    end
endmodule

// File: tb/tb_distortion_mc.sv
// Directed and randomized frames for distortion_mc, checked against an arithmetic reference
// model of the clip/mix rules plus latency, ramp and handshake checks.
module tb_distortion_mc;
    localparam int W  = 32;
    localparam int CH = 2;
    localparam int R  = 4;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic            CLOCK_50 = 1'b0;
    logic            resetn   = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [CH*W-1:0] in_data  = '0;
    logic            enable   = 1'b0;
    logic [1:0]      mode     = 2'b00;
    logic [1:0]      drive    = 2'b00;
    logic [1:0]      makeup   = 2'b00;
    logic [W-1:0]    soft_thresh = '0;
    logic [W-1:0]    hard_thresh = '0;
    logic            out_valid;
    logic [CH*W-1:0] out_data;
    logic            active;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;
    int g_model = 0;

    distortion_mc #(.W(W), .CH(CH), .RAMP_SHIFT(R)) dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .enable(enable), .mode(mode), .drive(drive), .makeup(makeup),
        .soft_thresh(soft_thresh), .hard_thresh(hard_thresh), .out_valid(out_valid),
        .out_data(out_data), .active(active)
    );

    always #5 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0d required=%0d", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    function automatic longint sat(input longint v);
        return (v > MAXV) ? MAXV : ((v < MINV) ? MINV : v);
    endfunction

    function automatic longint ref_y(input longint dry, input int md, input int dr, input int mk,
                                     input longint s_th, input longint h_in, input int g);
        longint h, x, a, c, wet, p, q;
        bit neg;
        h   = (h_in < s_th) ? s_th : h_in;
        x   = sat(dry * (64'sd1 << dr));
        neg = (x < 0);
        a   = (x == MINV) ? MAXV : (neg ? -x : x);
        case (md)
            0: c = a;
            1: if (a < s_th) c = a; else if (a < h) c = s_th + (a - s_th) / 2; else c = s_th + (h - s_th) / 2;
            2: c = (a < s_th) ? a : s_th;
            default: if (a <= s_th) c = a; else c = (2 * s_th - a > 0) ? 2 * s_th - a : 0;
        endcase
        wet = sat((neg ? -c : c) * (64'sd1 << mk));
        p   = (wet - dry) * g;
        q   = p / (64'sd1 << R);
        if (p < 0 && (p % (64'sd1 << R)) != 0) q = q - 1;
        return sat(dry + q);
    endfunction

    function automatic longint out_ch(input int k);
        logic [W-1:0] v;
        v = out_data[k*W +: W];
        return longint'($signed(v));
    endfunction

    task automatic run_frame(input longint d0, input longint d1, input bit en, input int md,
                             input int dr, input int mk, input logic [W-1:0] st,
                             input logic [W-1:0] ht, input string tag);
        longint din[CH];
        longint exp_y[CH];
        int t0, n;
        din[0] = d0;
        din[1] = d1;
        n = 0;
        @(negedge CLOCK_50);
        while (!in_ready && n < 20) begin
            @(negedge CLOCK_50);
            n++;
        end
        check({tag, " ready"}, longint'(in_ready), 1);
        for (int k = 0; k < CH; k++) in_data[k*W +: W] = din[k][W-1:0];
        enable = en; mode = md[1:0]; drive = dr[1:0]; makeup = mk[1:0];
        soft_thresh = st; hard_thresh = ht;
        in_valid = 1'b1;
        t0 = cyc;
        g_model = en ? ((g_model < (1 << R)) ? g_model + 1 : g_model) : ((g_model > 0) ? g_model - 1 : 0);
        for (int k = 0; k < CH; k++)
            exp_y[k] = ref_y(din[k], md, dr, mk, longint'(st), longint'(ht), g_model);
        @(negedge CLOCK_50);
        in_valid = 1'b0;
        // scramble controls mid-frame; the frame must keep its latched values
        in_data = {$urandom, $urandom};
        mode = 2'($urandom); drive = 2'($urandom); makeup = 2'($urandom);
        soft_thresh = $urandom; hard_thresh = $urandom; enable = 1'($urandom);
        check({tag, " active"}, longint'(active), longint'(g_model != 0));
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge CLOCK_50);
            n++;
        end
        check({tag, " latency"}, longint'(cyc - t0), CH + 2);
        for (int k = 0; k < CH; k++)
            check($sformatf("%s ch%0d", tag, k), out_ch(k), exp_y[k]);
        @(negedge CLOCK_50);
        check({tag, " pulse"}, longint'(out_valid), 0);
    endtask

    initial begin
        int acc_cnt, pulse_cnt, last_acc;
        longint d, e;

        repeat (3) @(negedge CLOCK_50);
        check("rst in_ready", longint'(in_ready), 1);
        check("rst out_valid", longint'(out_valid), 0);
        check("rst out_data", longint'(out_data == '0), 1);
        check("rst active", longint'(active), 0);
        resetn = 1'b1;

        run_frame(987654, -123456, 1'b0, 1, 0, 0, 32'd1000, 32'd2000, "bypass_gain");
        check("bypass ch0 exact", out_ch(0), 987654);
        check("bypass ch1 exact", out_ch(1), -123456);

        for (int i = 0; i < 16; i++) begin
            run_frame(1000000, 1000000, 1'b1, 2, 0, 0, 32'd0, 32'd0, $sformatf("ramp_up%0d", i));
            check($sformatf("ramp_up%0d const", i), out_ch(0), 1000000 - 62500 * (i + 1));
        end

        run_frame(5000000, 5000000, 1'b1, 1, 2, 1, 32'd15000000, 32'd30000000, "soft_pos");
        check("soft_pos const", out_ch(1), 35000000);
        run_frame(-9000000, -9000000, 1'b1, 1, 2, 1, 32'd15000000, 32'd30000000, "soft_neg");
        check("soft_neg const", out_ch(0), -45000000);

        run_frame(MINV, MAXV, 1'b1, 0, 3, 1, 32'd0, 32'd0, "sat");
        check("sat min", out_ch(0), MINV);
        check("sat max", out_ch(1), MAXV);

        run_frame(15000000, 30000000, 1'b1, 3, 0, 0, 32'd10000000, 32'd0, "fold");
        check("fold 15M", out_ch(0), 5000000);
        check("fold 30M", out_ch(1), 0);

        for (int i = 0; i < 16; i++) begin
            run_frame(1000000, 1000000, 1'b0, 2, 0, 0, 32'd0, 32'd0, $sformatf("ramp_dn%0d", i));
            check($sformatf("ramp_dn%0d const", i), out_ch(0), 62500 * (i + 1));
        end

        for (int i = 0; i < 40; i++) begin
            d = longint'($signed(32'($urandom)));
            e = longint'($signed(32'($urandom))) >>> $urandom_range(0, 20);
            run_frame(d, e, 1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), 32'($urandom >> $urandom_range(0, 31)),
                      32'($urandom >> $urandom_range(0, 31)), $sformatf("rnd%0d", i));
        end

        // in_valid held continuously: accepts every CH+3 cycles, one pulse per accept
        @(negedge CLOCK_50);
        enable = 1'b0; mode = 2'b00; in_valid = 1'b1;
        acc_cnt = 0; pulse_cnt = 0; last_acc = -1;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) pulse_cnt++;
            if (in_ready) begin
                if (last_acc >= 0) check("hs gap", longint'(cyc - last_acc), CH + 3);
                last_acc = cyc;
                acc_cnt++;
                g_model = (g_model > 0) ? g_model - 1 : 0;
            end
            @(negedge CLOCK_50);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) pulse_cnt++;
            @(negedge CLOCK_50);
        end
        check("hs accepts", longint'(acc_cnt), 8);
        check("hs pulses", longint'(pulse_cnt), longint'(acc_cnt));

        // reset at T+2 of a frame
        in_data = {32'd1000000, 32'd1000000}; enable = 1'b1; mode = 2'b10;
        soft_thresh = '0; in_valid = 1'b1;
        @(negedge CLOCK_50);
        in_valid = 1'b0;
        @(negedge CLOCK_50);
        resetn = 1'b0;
        g_model = 0;
        pulse_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLOCK_50);
            if (out_valid) pulse_cnt++;
        end
        check("midrst pulses", longint'(pulse_cnt), 0);
        check("midrst out_data", longint'(out_data == '0), 1);
        check("midrst active", longint'(active), 0);
        check("midrst in_ready", longint'(in_ready), 1);
        resetn = 1'b1;
        run_frame(1000000, 1000000, 1'b1, 2, 0, 0, 32'd0, 32'd0, "post_rst");
        check("post_rst g restart", out_ch(0), 937500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/distortion_mc.md
# distortion_mc

Parametrised, time-multiplexed multi-channel distortion stage for the audio path, sitting between the codec receive FIFO and the output mixer. It accepts one frame of CH signed samples per handshake and processes the channels serially through a two-stage saturating datapath. Four selectable clip modes and runtime drive, threshold and makeup controls are available. A per-frame wet/dry ramp makes enable/disable click-free.

## Interface
- W, 32: sample width in bits (signed), 16..32
- CH, 2: channels per frame, 1..8
- RAMP_SHIFT, 4: wet/dry ramp length is 2^RAMP_SHIFT frames
- CLOCK_50  in  1  system clock; all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- in_valid  in  1  frame present on in_data
- in_ready  out  1  block idle and able to accept a frame
- in_data  in  CH*W  channel k in bits [k*W +: W], signed
- enable  in  1  target effect state; sampled at accept
- mode  in  2  00 bypass, 01 soft knee, 10 hard clip, 11 fold; sampled at accept
- drive  in  2  pre-gain shift 0..3; sampled at accept
- makeup  in  2  post-gain shift 0..3; sampled at accept
- soft_thresh  in  W  knee threshold, treated as unsigned magnitude; sampled at accept
- hard_thresh  in  W  cap threshold; sampled at accept
- out_valid  out  1  one-cycle pulse; out_data valid on the same cycle and held until the next frame overwrites it
- out_data  out  CH*W  processed frame, same packing as in_data
- active  out  1  high while the ramp gain g != 0

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE. in_ready = (state == IDLE).
- Accept: in_valid & in_ready. Latch in_data, mode, drive, makeup and thresholds. If hard_thresh < soft_thresh, the latched hard value equals soft. Update the ramp gain g by +1 if enable, else -1, clamped to [0, 2^RAMP_SHIFT]. The frame uses the updated g. Go to RUN with channel counter = 0.
- RUN: feed channel k into stage 1 each cycle. After k = CH-1 go to DRAIN. DRAIN lasts one cycle, then DONE. DONE asserts out_valid, then returns to IDLE.
- Stage 1, per channel: x = dry <<< drive, computed at W+4 bits and saturated to the W-bit signed range. s = sign(x). a = |x|, with the most-negative value mapping to 2^(W-1)-1.
- Stage 2, clip on a; S = soft, H = hard:
  - bypass: c = a.
  - soft knee: a < S gives c = a; a < H gives c = S + ((a-S) >> 1); otherwise c = S + ((H-S) >> 1).
  - hard clip: c = min(a, S).
  - fold: a <= S gives c = a; otherwise c = max(2S - a, 0).
- Then wet = (s ? -c : c) <<< makeup, saturated to W bits.
- Mix: y = dry + (((wet - dry) * g) >>>_floor RAMP_SHIFT), computed at W+RAMP_SHIFT+2 bits and saturated to W bits. g = 0 gives y = dry bit-exact. g = 2^RAMP_SHIFT gives y = wet bit-exact. Write y into out_data channel k.
- in_valid asserted while in_ready is low is ignored and not queued. The upstream holds the frame.

## Timing
- Accept at cycle T. Channel k is written at the end of cycle T+2+k. out_valid is high in cycle T+CH+2.
- in_ready is low from T+1 through T+CH+2. Earliest next accept is T+CH+3, giving a minimum frame period of CH+3 cycles.
- Control inputs are used only at accept. Changes mid-frame have no effect on that frame.
- Reset (async, any state, including mid-frame) forces:
  - state IDLE, in_ready = 1
  - out_valid = 0, out_data = 0
  - g = 0, active = 0
  - all pipeline registers 0
- The first accept after reset is handled normally.
- active changes only at the cycle after an accept.

## Test plan
- Reset/idle: hold resetn = 0, then release. Required: in_ready = 1, out_valid = 0, out_data = 0, active = 0. Assert resetn = 0 at T+2 of a frame: no out_valid pulse follows and the ramp restarts from g = 0.
- Bypass by gain: enable = 0, mode = 01, CH = 2, in_data = {-123456, 987654}. Required: out_data is identical to the input, out_valid exactly at T+4, active = 0.
- Soft knee, full ramp: 16 frames with enable = 1, then a frame with in = 5,000,000 on both channels, drive = 2, makeup = 1, soft = 15,000,000, hard = 30,000,000. Required: 35,000,000 on both channels. With in = -9,000,000 the required output is -45,000,000.
- Ramp: constant in = 1,000,000, mode = 10, soft = 0 (wet = 0), enable = 1 for 16 frames. Required: outputs 937,500, 875,000, ... down to 0. Then enable = 0: outputs step back up by 62,500 per frame.
- Saturation: full ramp, mode = 00, drive = 3, in = -2^31 and 2^31-1. Required: -2^31 and 2^31-1, with no wrap. Fold mode with soft = 10,000,000, drive = 0, in = 15,000,000 gives 5,000,000. Fold with in = 30,000,000 gives 0.
- Handshake: in_valid held high continuously. Required: accepts exactly every CH+3 cycles, and frames asserted while busy are not double-counted.
